// File: rtl/hash_arbiter_if.sv
// hash_arbiter_if: requester, response and hasher-side signals of hash_arbiter.
// The slave modport is the arbiter's view; master is the requester/hasher side.
interface hash_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
);
  logic [N_REQ-1:0]    req;
  logic [16*N_REQ-1:0] req_id;
  logic [N_REQ-1:0]    gnt;
  logic                resp_valid;
  logic [IDX_W-1:0]    resp_idx;
  logic [15:0]         resp_hash;
  logic                busy;
  logic [15:0]         hsh_time;
  logic [15:0]         hsh_id;
  logic [15:0]         hsh_hash;

  modport slave (
    input  req, req_id, hsh_hash,
    output gnt, resp_valid, resp_idx, resp_hash, busy, hsh_time, hsh_id
  );

  modport master (
    output req, req_id, hsh_hash,
    input  gnt, resp_valid, resp_idx, resp_hash, busy, hsh_time, hsh_id
  );
endinterface

// File: rtl/hash_arbiter.sv
// hash_arbiter: shares one hasher between N_REQ requesters and owns its time counter.
// HASH_ARB_RR_EN defined selects round-robin arbitration; undefined gives fixed lowest-index priority.
module hash_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned IDX_W     = 2,
  parameter logic [15:0] TIME_INIT = 16'h0
) (
  input logic           clk,
  input logic           rst,
  hash_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t           r_state;
  logic [15:0]      r_time;
  logic [N_REQ-1:0] r_gnt;
  logic             r_resp_valid;
  logic [IDX_W-1:0] r_resp_idx;
  logic [15:0]      r_resp_hash;
  logic             r_busy;
  logic [15:0]      r_hsh_id;
  logic [IDX_W-1:0] r_win;

  logic             w_any;
  logic [IDX_W-1:0] w_win;
  logic [15:0]      w_win_id;
  int unsigned      w_start;
  int unsigned      w_k;

`ifdef HASH_ARB_RR_EN
  logic [IDX_W-1:0] r_ptr;
  assign w_start = 32'(r_ptr);
`else
  assign w_start = 0;
`endif

  // Scan starting at w_start, wrapping; the first set request wins.
  always_comb begin
    w_any    = 1'b0;
    w_win    = '0;
    w_win_id = '0;
    w_k      = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_k = (w_start + i) % N_REQ;
      if (!w_any && bus.req[IDX_W'(w_k)]) begin
        w_any    = 1'b1;
        w_win    = IDX_W'(w_k);
        w_win_id = bus.req_id[16*w_k +: 16];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_time       <= TIME_INIT;
      r_gnt        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_idx   <= '0;
      r_resp_hash  <= '0;
      r_busy       <= 1'b0;
      r_hsh_id     <= '0;
      r_win        <= '0;
`ifdef HASH_ARB_RR_EN
      r_ptr        <= '0;
`endif
    end else begin
      r_time <= r_time + 16'd1;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state  <= S_GRANT;
            r_win    <= w_win;
            r_gnt    <= N_REQ'(1) << w_win;
            r_hsh_id <= w_win_id;
            r_busy   <= 1'b1;
`ifdef HASH_ARB_RR_EN
            r_ptr    <= IDX_W'((32'(w_win) + 32'd1) % N_REQ);
`endif
          end
        end
        S_GRANT: begin
          r_state  <= S_CAPTURE;
          r_gnt    <= '0;
          r_hsh_id <= '0;
        end
        // Hasher sampled the GRANT-cycle ID on the edge entering this state.
        S_CAPTURE: begin
          r_state      <= S_RESP;
          r_resp_hash  <= bus.hsh_hash;
          r_resp_idx   <= r_win;
          r_resp_valid <= 1'b1;
        end
        S_RESP: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
          r_busy       <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_idx   = r_resp_idx;
  assign bus.resp_hash  = r_resp_hash;
  assign bus.busy       = r_busy;
  assign bus.hsh_time   = r_time;
  assign bus.hsh_id     = r_hsh_id;

endmodule

// File: tb/tb_hash_arbiter.sv
// tb_hash_arbiter: directed bench for hash_arbiter with a stub hasher (hash = id ^ 16'hA5A5).
// Expectations for HASH_ARB_RR_EN follow the same macro used to build the DUT.
module tb_hash_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  hash_arbiter_if #(.N_REQ(4), .IDX_W(2)) bus ();
  hash_arbiter_if #(.N_REQ(4), .IDX_W(2)) bus2 ();

  hash_arbiter #(.N_REQ(4), .IDX_W(2), .TIME_INIT(16'h0000)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  hash_arbiter #(.N_REQ(4), .IDX_W(2), .TIME_INIT(16'hFFFE)) u_dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  assign bus2.req      = '0;
  assign bus2.req_id   = '0;
  assign bus2.hsh_hash = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.hsh_hash <= bus.hsh_id ^ 16'hA5A5;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.req    = '0;
    bus.req_id = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (bus.hsh_time !== 16'h0000) begin
      failures++; $display("FAIL reset_time got=%h exp=%h", bus.hsh_time, 16'h0000);
    end
    checks++;
    if ({bus.gnt, bus.resp_valid, bus.resp_idx, bus.resp_hash, bus.busy, bus.hsh_id} !== '0) begin
      failures++; $display("FAIL reset_outputs gnt=%b rv=%b idx=%0d hash=%h busy=%b id=%h exp=all zero",
                           bus.gnt, bus.resp_valid, bus.resp_idx, bus.resp_hash, bus.busy, bus.hsh_id);
    end
    repeat (5) tick();
    checks++;
    if (bus.hsh_time !== 16'h0005) begin
      failures++; $display("FAIL idle_time got=%h exp=%h", bus.hsh_time, 16'h0005);
    end
    checks++;
    if ({bus.gnt, bus.resp_valid, bus.busy, bus.hsh_id} !== '0) begin
      failures++; $display("FAIL idle_outputs gnt=%b rv=%b busy=%b id=%h exp=all zero",
                           bus.gnt, bus.resp_valid, bus.busy, bus.hsh_id);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.req    = 4'b0001;
    bus.req_id = {16'h0, 16'h0, 16'h0, 16'h1234};
    tick();
    checks++;
    if (bus.gnt !== 4'b0001 || bus.hsh_id !== 16'h1234 || bus.busy !== 1'b1) begin
      failures++; $display("FAIL single_grant gnt=%b id=%h busy=%b exp gnt=0001 id=1234 busy=1",
                           bus.gnt, bus.hsh_id, bus.busy);
    end
    bus.req = '0;
    tick();
    checks++;
    if (bus.gnt !== 4'b0000 || bus.hsh_id !== 16'h0000 || bus.resp_valid !== 1'b0) begin
      failures++; $display("FAIL single_capture gnt=%b id=%h rv=%b exp gnt=0000 id=0000 rv=0",
                           bus.gnt, bus.hsh_id, bus.resp_valid);
    end
    tick();
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_hash !== 16'hB791 || bus.resp_idx !== 2'd0) begin
      failures++; $display("FAIL single_resp rv=%b hash=%h idx=%0d exp rv=1 hash=b791 idx=0",
                           bus.resp_valid, bus.resp_hash, bus.resp_idx);
    end
    checks++;
    if (bus.hsh_time !== 16'h0003) begin
      failures++; $display("FAIL single_time got=%h exp=%h", bus.hsh_time, 16'h0003);
    end
    tick();
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.resp_hash !== 16'hB791) begin
      failures++; $display("FAIL single_hold rv=%b busy=%b hash=%h exp rv=0 busy=0 hash=b791",
                           bus.resp_valid, bus.busy, bus.resp_hash);
    end
  endtask

  task automatic test_two_pending();
    logic [1:0]  exp_idx [2];
    logic [15:0] exp_hash[2];
    logic [3:0]  exp_gnt;
    exp_idx[0] = 2'd1; exp_hash[0] = 16'hA5A4;
`ifdef HASH_ARB_RR_EN
    exp_idx[1] = 2'd3; exp_hash[1] = 16'hA5A6;
`else
    exp_idx[1] = 2'd1; exp_hash[1] = 16'hA5A4;
`endif
    do_reset();
    bus.req    = 4'b1010;
    bus.req_id = {16'h0003, 16'h0, 16'h0001, 16'h0};
    for (int op = 0; op < 2; op++) begin
      exp_gnt = 4'b0001 << exp_idx[op];
      tick();
      checks++;
      if (bus.gnt !== exp_gnt) begin
        failures++; $display("FAIL two_grant op=%0d got=%b exp=%b", op, bus.gnt, exp_gnt);
      end
      tick();
      tick();
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_idx !== exp_idx[op] || bus.resp_hash !== exp_hash[op]) begin
        failures++; $display("FAIL two_resp op=%0d rv=%b idx=%0d hash=%h exp rv=1 idx=%0d hash=%h",
                             op, bus.resp_valid, bus.resp_idx, bus.resp_hash, exp_idx[op], exp_hash[op]);
      end
      tick();
    end
    bus.req = '0;
  endtask

  task automatic test_back_to_back();
    int          exp_order[5];
    logic [3:0]  exp_gnt;
    logic [15:0] exp_hash;
`ifdef HASH_ARB_RR_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 0, 0, 0, 0};
`endif
    do_reset();
    bus.req    = 4'b1111;
    bus.req_id = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
    for (int op = 0; op < 5; op++) begin
      exp_gnt  = 4'b0001 << exp_order[op];
      exp_hash = (16'h0100 * 16'(exp_order[op] + 1)) ^ 16'hA5A5;
      tick();
      checks++;
      if (bus.gnt !== exp_gnt) begin
        failures++; $display("FAIL b2b_grant op=%0d got=%b exp=%b", op, bus.gnt, exp_gnt);
      end
      tick();
      checks++;
      if (bus.gnt !== 4'b0000) begin
        failures++; $display("FAIL b2b_pulse op=%0d got=%b exp=0000", op, bus.gnt);
      end
      tick();
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_idx !== 2'(exp_order[op]) || bus.resp_hash !== exp_hash) begin
        failures++; $display("FAIL b2b_resp op=%0d rv=%b idx=%0d hash=%h exp rv=1 idx=%0d hash=%h",
                             op, bus.resp_valid, bus.resp_idx, bus.resp_hash, exp_order[op], exp_hash);
      end
      tick();
    end
    bus.req = '0;
  endtask

  task automatic test_reset_abort();
    do_reset();
    bus.req    = 4'b0001;
    bus.req_id = {16'h0, 16'h0, 16'h0, 16'h5555};
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.gnt, bus.resp_valid, bus.resp_idx, bus.resp_hash, bus.busy, bus.hsh_id} !== '0) begin
      failures++; $display("FAIL abort_outputs gnt=%b rv=%b idx=%0d hash=%h busy=%b id=%h exp=all zero",
                           bus.gnt, bus.resp_valid, bus.resp_idx, bus.resp_hash, bus.busy, bus.hsh_id);
    end
    tick();
    checks++;
    if (bus.gnt !== 4'b0001 || bus.resp_valid !== 1'b0) begin
      failures++; $display("FAIL abort_regrant gnt=%b rv=%b exp gnt=0001 rv=0", bus.gnt, bus.resp_valid);
    end
    bus.req = '0;
    tick();
    tick();
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_hash !== 16'hF0F0 || bus.resp_idx !== 2'd0) begin
      failures++; $display("FAIL abort_resp rv=%b hash=%h idx=%0d exp rv=1 hash=f0f0 idx=0",
                           bus.resp_valid, bus.resp_hash, bus.resp_idx);
    end
    tick();
  endtask

  task automatic test_time_wrap();
    logic [15:0] exp_t[4];
    exp_t = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus2.hsh_time !== exp_t[i]) begin
        failures++; $display("FAIL time_wrap step=%0d got=%h exp=%h", i, bus2.hsh_time, exp_t[i]);
      end
      tick();
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    bus.req    = '0;
    bus.req_id = '0;
    #1;
    test_reset();
    test_single();
    test_two_pending();
    test_back_to_back();
    test_reset_abort();
    test_time_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
